// File: rtl/fifo_pkg.sv
// Shared constants and types for the single-clock FIFO.
package fifo_pkg;

    localparam int WIDTH_DEF     = 8;
    localparam int PTR_WIDTH_DEF = 3;
    localparam int DEPTH_DEF     = 1 << PTR_WIDTH_DEF;

    // Pointer with one extra wrap bit to tell full from empty.
    typedef logic [PTR_WIDTH_DEF:0] ptr_t;

endpackage

// File: rtl/fifo_mem.sv
// Register-array storage: one synchronous write port, one registered read port.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int PTR_WIDTH = PTR_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [PTR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic                 re,
    input  logic [PTR_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]     rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage itself is never cleared; only the pointers define contents.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fifo.sv
// Single-clock FIFO: pointer counters, full/empty flags and storage.
module fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int PTR_WIDTH = PTR_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] w_data,
    input  logic             source_w_en,
    input  logic             destination_r_en,
    output logic [WIDTH-1:0] r_data,
    output logic             w_full,
    output logic             r_empty
);

    logic [PTR_WIDTH:0] wptr;
    logic [PTR_WIDTH:0] rptr;
    logic               w_acc;
    logic               r_acc;

    // Same index with differing wrap bits means the writer lapped the reader.
    assign r_empty = (wptr == rptr);
    assign w_full  = (wptr[PTR_WIDTH] != rptr[PTR_WIDTH]) &&
                     (wptr[PTR_WIDTH-1:0] == rptr[PTR_WIDTH-1:0]);

    assign w_acc = source_w_en && !w_full;
    assign r_acc = destination_r_en && !r_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
        end else if (w_acc) begin
            wptr <= wptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rptr <= '0;
        end else if (r_acc) begin
            rptr <= rptr + 1'b1;
        end
    end

    fifo_mem #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .PTR_WIDTH (PTR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .rst_n (reset),
        .we    (w_acc),
        .waddr (wptr[PTR_WIDTH-1:0]),
        .wdata (w_data),
        .re    (r_acc),
        .raddr (rptr[PTR_WIDTH-1:0]),
        .rdata (r_data)
    );

endmodule

// File: tb/tb_fifo.sv
// Scoreboard bench for fifo: driver predicts reads, monitor checks r_data.
module tb_fifo;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] w_data = '0;
    logic       source_w_en = 1'b0;
    logic       destination_r_en = 1'b0;
    logic [7:0] r_data;
    logic       w_full;
    logic       r_empty;

    int checks = 0;
    int failures = 0;

    logic [7:0] mq [$];
    logic [7:0] expq [$];
    logic [7:0] last_rd = '0;
    logic       rd_fire = 1'b0;

    fifo dut (
        .clk              (clk),
        .reset            (reset),
        .w_data           (w_data),
        .source_w_en      (source_w_en),
        .destination_r_en (destination_r_en),
        .r_data           (r_data),
        .w_full           (w_full),
        .r_empty          (r_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: a read accepted at a rising edge presents data by the falling edge.
    always @(posedge clk or negedge reset) begin
        if (!reset) rd_fire <= 1'b0;
        else        rd_fire <= destination_r_en && !r_empty;
    end

    always @(negedge clk) begin
        if (rd_fire) begin
            if (expq.size() == 0) begin
                chk("unexpected_read", 1, 0);
            end else begin
                chk("r_data", int'(r_data), int'(expq.pop_front()));
            end
        end
    end

    // Driver: checks flags against model, then drives one cycle and predicts it.
    task automatic step(input logic w, input logic r, input logic [7:0] d);
        logic wacc;
        logic racc;
        @(negedge clk);
        chk("r_empty", int'(r_empty), int'(mq.size() == 0));
        chk("w_full", int'(w_full), int'(mq.size() == 8));
        chk("r_data_hold", int'(r_data), int'(last_rd));
        wacc = w && (mq.size() < 8);
        racc = r && (mq.size() > 0);
        if (racc) begin
            last_rd = mq.pop_front();
            expq.push_back(last_rd);
        end
        if (wacc) mq.push_back(d);
        source_w_en = w;
        destination_r_en = r;
        w_data = d;
    endtask

    initial begin
        int next_v;
        int cyc;
        reset = 1'b0;
        #12;
        chk("rst_empty", int'(r_empty), 1);
        chk("rst_full", int'(w_full), 0);
        chk("rst_rdata", int'(r_data), 0);
        reset = 1'b1;

        // Mid-stream reset: put words in, read one, then reset asynchronously.
        for (int i = 1; i <= 3; i++) step(1'b1, 1'b0, 8'(8'h30 + i));
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        @(negedge clk);
        source_w_en = 1'b0;
        destination_r_en = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("async_rst_empty", int'(r_empty), 1);
        chk("async_rst_full", int'(w_full), 0);
        chk("async_rst_rdata", int'(r_data), 0);
        mq.delete();
        expq.delete();
        last_rd = '0;
        #1 reset = 1'b1;

        // Fill 1..8, then a refused 9th write.
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 8'(i));
        step(1'b1, 1'b0, 8'd9);
        step(1'b0, 1'b0, 8'd0);
        chk("full_after_fill", int'(w_full), 1);

        // Drain 8, then a refused 9th read.
        for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, 8'd0);
        step(1'b0, 1'b1, 8'd0);
        step(1'b0, 1'b0, 8'd0);
        chk("drain_last", int'(r_data), 8);
        chk("empty_after_drain", int'(r_empty), 1);

        // Simultaneous read+write while empty.
        step(1'b1, 1'b1, 8'd5);
        step(1'b0, 1'b0, 8'd0);
        chk("empty_sim_not_empty", int'(r_empty), 0);
        chk("empty_sim_rdata", int'(r_data), 8);

        // Fill up, then simultaneous read+write while full.
        for (int i = 6; i <= 12; i++) step(1'b1, 1'b0, 8'(i));
        step(1'b1, 1'b1, 8'hAA);
        step(1'b0, 1'b0, 8'd0);
        chk("full_sim_rdata", int'(r_data), 5);
        chk("full_sim_not_full", int'(w_full), 0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'd0);
        step(1'b0, 1'b0, 8'd0);
        chk("full_sim_tail", int'(r_data), 12);

        // Streaming 1..80 with random enables.
        next_v = 1;
        cyc = 0;
        while ((next_v <= 80 || mq.size() > 0) && cyc < 3000) begin
            logic w;
            logic r;
            w = (next_v <= 80) && ($urandom % 2 == 1);
            r = ($urandom % 2 == 1);
            step(w, r, 8'(next_v));
            if (w && mq.size() > 0 && mq[mq.size()-1] == 8'(next_v)) next_v++;
            cyc++;
        end
        chk("stream_budget", int'(cyc < 3000), 1);
        step(1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b0, 8'd0);
        chk("stream_last", int'(r_data), 80);
        chk("scoreboard_drained", expq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
